// File: rtl/map_pkg.sv
// Shared types and constants for the wall-map engine and the game top level.
package map_pkg;

  localparam int FB_W    = 320;
  localparam int FB_SIZE = 76800;

  // Collision query FSM states
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } coll_state_t;

  // Game-state encodings used by the top-level game controller
  typedef enum logic [2:0] {
    TITLE,
    STAGE_SEL,
    PLAY,
    WIN,
    FAIL
  } game_state_t;

endpackage

// File: rtl/map_collision_fsm.sv
// Player-box collision query: scans PLAYER_CELLS rows of the selected map,
// one row per cycle, through the second read port of the map array.
module map_collision_fsm
  import map_pkg::*;
#(
  parameter int GRID_W       = 40,
  parameter int GRID_H       = 40,
  parameter int NUM_MAPS     = 4,
  parameter int PLAYER_CELLS = 4,
  parameter int MAP_W        = $clog2(NUM_MAPS),
  parameter int XW           = $clog2(GRID_W) + 1,
  parameter int YW           = $clog2(GRID_H) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [MAP_W-1:0]  q_map,
  input  logic [XW-1:0]     q_x,
  input  logic [YW-1:0]     q_y,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [MAP_W-1:0]  rd_map,
  output logic [YW:0]       rd_row,
  input  logic [GRID_W-1:0] rd_data
);

  localparam int CW = $clog2(PLAYER_CELLS + 1);
  localparam int RW = YW + 1;

  coll_state_t        state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [MAP_W-1:0]   cap_map;
  logic [XW-1:0]      cap_x;
  logic [YW-1:0]      cap_y;
  logic               acc;
  logic               row_oob;

  // OR of the box columns in one row; columns past the grid edge are walls.
  function automatic logic box_hit(input logic [XW-1:0] x0, input logic [GRID_W-1:0] bits);
    logic h;
    int   c;
    h = 1'b0;
    for (int j = 0; j < PLAYER_CELLS; j++) begin
      c = int'(x0) + j;
      if (c >= GRID_W)             h = 1'b1;
      else if (bits[GRID_W-1-c])   h = 1'b1;
    end
    return h;
  endfunction

  assign rd_map  = cap_map;
  assign rd_row  = {1'b0, cap_y} + RW'(cnt);
  assign row_oob = (rd_row >= RW'(GRID_H));

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    q_ready   = 1'b0;
    case (state)
      IDLE: begin
        q_ready = 1'b1;
        if (q_valid) state_nxt = SCAN;
      end
      SCAN:    if (cnt == CW'(PLAYER_CELLS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, query capture, hit accumulation and registered one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_map    <= '0;
      cap_x      <= '0;
      cap_y      <= '0;
      acc        <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= (state == DONE);
      resp_hit   <= (state == DONE) & acc;
      case (state)
        IDLE: if (q_valid) begin
          cap_map <= q_map;
          cap_x   <= q_x;
          cap_y   <= q_y;
          acc     <= 1'b0;
          cnt     <= '0;
        end
        SCAN: begin
          acc <= acc | row_oob | box_hit(cap_x, rd_data);
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/map_engine.sv
// Wall-map store with a two-stage render lookup and a collision query port.
module map_engine
  import map_pkg::*;
#(
  parameter int GRID_W       = 40,
  parameter int GRID_H       = 40,
  parameter int TILE         = 5,
  parameter int ORG_X        = 60,
  parameter int ORG_Y        = 30,
  parameter int NUM_MAPS     = 4,
  parameter int PLAYER_CELLS = 4,
  parameter int TEX_ROW      = 120
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(NUM_MAPS)-1:0]   map_sel,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  output logic [16:0]                   pixel_addr,
  output logic                          is_wall,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_MAPS)-1:0]   wr_map,
  input  logic [$clog2(GRID_H)-1:0]     wr_row,
  input  logic [GRID_W-1:0]             wr_data,
  input  logic                          q_valid,
  output logic                          q_ready,
  input  logic [$clog2(NUM_MAPS)-1:0]   q_map,
  input  logic [$clog2(GRID_W):0]       q_x,
  input  logic [$clog2(GRID_H):0]       q_y,
  output logic                          resp_valid,
  output logic                          resp_hit
);

  localparam int MAP_W = $clog2(NUM_MAPS);
  localparam int ROW_W = $clog2(GRID_H);
  localparam int COL_W = $clog2(GRID_W);
  localparam int SUB_W = $clog2(TILE + 1);

  localparam logic [16:0] OX  = 17'(ORG_X);
  localparam logic [16:0] OY  = 17'(ORG_Y);
  localparam logic [16:0] EX  = 17'(ORG_X + GRID_W * TILE);
  localparam logic [16:0] EY  = 17'(ORG_Y + GRID_H * TILE);
  localparam logic [16:0] TL  = 17'(TILE);

  logic [GRID_W-1:0] mem [NUM_MAPS][GRID_H];

  // Map rows; reset clears every stored wall bit, rows past the grid are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NUM_MAPS; m++)
        for (int r = 0; r < GRID_H; r++)
          mem[m][r] <= '0;
    end else if (wr_en && (int'(wr_row) < GRID_H)) begin
      mem[wr_map][wr_row] <= wr_data;
    end
  end

  // ---------------- render stage 1: window test and cell split
  logic [16:0] x, y, dx, dy;
  logic        in_win;

  assign x      = 17'(h_cnt) >> 1;
  assign y      = 17'(v_cnt) >> 1;
  assign dx     = x - OX;
  assign dy     = y - OY;
  assign in_win = (x >= OX) && (x < EX) && (y >= OY) && (y < EY);

  logic             s1_in;
  logic [ROW_W-1:0] s1_row;
  logic [COL_W-1:0] s1_col;
  logic [SUB_W-1:0] s1_sx, s1_sy;
  logic [MAP_W-1:0] s1_map;

  // Cell coordinates are forced to 0 outside the window so stage 2 never indexes past the grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in  <= 1'b0;
      s1_row <= '0;
      s1_col <= '0;
      s1_sx  <= '0;
      s1_sy  <= '0;
      s1_map <= '0;
    end else begin
      s1_in  <= in_win;
      s1_row <= in_win ? ROW_W'(dy / TL) : '0;
      s1_col <= in_win ? COL_W'(dx / TL) : '0;
      s1_sx  <= in_win ? SUB_W'(dx % TL) : '0;
      s1_sy  <= in_win ? SUB_W'(dy % TL) : '0;
      s1_map <= map_sel;
    end
  end

  // ---------------- render stage 2: map bit and texture address
  logic [COL_W-1:0] bit_idx;
  logic             pix_bit;
  logic [16:0]      tex;

  assign bit_idx = COL_W'(GRID_W - 1) - s1_col;
  assign pix_bit = mem[s1_map][s1_row][bit_idx];
  assign tex     = (17'(s1_sx) + (17'(s1_sy) + 17'(TEX_ROW)) * 17'(FB_W)) % 17'(FB_SIZE);

  // Registered pixel-mux outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wall    <= 1'b0;
      pixel_addr <= '0;
    end else begin
      is_wall    <= s1_in & pix_bit;
      pixel_addr <= (s1_in & pix_bit) ? tex : '0;
    end
  end

  // ---------------- collision query port
  logic [MAP_W-1:0]  rd_map;
  logic [ROW_W+1:0]  rd_row;
  logic [GRID_W-1:0] rd_data;

  assign rd_data = (rd_row < (ROW_W+2)'(GRID_H)) ? mem[rd_map][rd_row[ROW_W-1:0]] : '0;

  map_collision_fsm #(
    .GRID_W       (GRID_W),
    .GRID_H       (GRID_H),
    .NUM_MAPS     (NUM_MAPS),
    .PLAYER_CELLS (PLAYER_CELLS),
    .MAP_W        (MAP_W),
    .XW           (COL_W + 1),
    .YW           (ROW_W + 1)
  ) u_coll (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_map      (q_map),
    .q_x        (q_x),
    .q_y        (q_y),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .rd_map     (rd_map),
    .rd_row     (rd_row),
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_map_engine.sv
// Scoreboard bench for map_engine: render and query expectations are queued
// when stimulus is driven and compared when the corresponding output appears.
module tb_map_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  map_sel = '0;
  logic [9:0]  h_cnt = '0, v_cnt = '0;
  logic [16:0] pixel_addr;
  logic        is_wall;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_map = '0;
  logic [5:0]  wr_row = '0;
  logic [39:0] wr_data = '0;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [1:0]  q_map = '0;
  logic [6:0]  q_x = '0, q_y = '0;
  logic        resp_valid, resp_hit;

  map_engine dut (
    .clk(clk), .rst_n(rst_n), .map_sel(map_sel), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pixel_addr(pixel_addr), .is_wall(is_wall), .wr_en(wr_en), .wr_map(wr_map),
    .wr_row(wr_row), .wr_data(wr_data), .q_valid(q_valid), .q_ready(q_ready),
    .q_map(q_map), .q_x(q_x), .q_y(q_y), .resp_valid(resp_valid), .resp_hit(resp_hit)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct { logic w; logic [16:0] a; } pix_t;
  typedef struct { logic hit; int acc; } qry_t;
  pix_t pix_q[$];
  qry_t qry_q[$];

  logic [39:0] mem_m [4][40];
  logic        drv_pix = 1'b0;
  logic [1:0]  tagp;

  always @(posedge clk) cyc <= cyc + 1;

  // Delay line marking which cycles carry a scored pixel out of the pipeline
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tagp <= '0;
    else        tagp <= {tagp[0], drv_pix};

  always @(negedge clk) begin
    pix_t e;
    if (tagp[1]) begin
      if (pix_q.size() == 0) chk("pix_underflow", 1, 0);
      else begin
        e = pix_q.pop_front();
        chk("is_wall", is_wall, e.w);
        chk("pixel_addr", pixel_addr, e.a);
      end
    end
  end

  always @(negedge clk) begin
    qry_t e;
    if (resp_valid) begin
      if (qry_q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        e = qry_q.pop_front();
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_latency", cyc - e.acc, 5);
      end
    end
  end

  function automatic void pmodel(input int h, input int v, input int s,
                                 output logic w, output logic [16:0] a);
    int x, y, col, row;
    x = h / 2; y = v / 2; w = 1'b0; a = '0;
    if (x >= 60 && x < 260 && y >= 30 && y < 230) begin
      col = (x - 60) / 5;
      row = (y - 30) / 5;
      if (mem_m[s][row][39-col]) begin
        w = 1'b1;
        a = 17'((((x - 60) % 5) + (((y - 30) % 5) + 120) * 320) % 76800);
      end
    end
  endfunction

  function automatic logic cmodel(input int m, input int x, input int y);
    logic h = 1'b0;
    for (int r = y; r < y + 4; r++)
      for (int c = x; c < x + 4; c++)
        if (r >= 40 || c >= 40) h = 1'b1;
        else if (mem_m[m][r][39-c]) h = 1'b1;
    return h;
  endfunction

  task automatic wr(input int m, input int r, input logic [39:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_map = 2'(m); wr_row = 6'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (r < 40) mem_m[m][r] = d;
  endtask

  task automatic pix_e(input int h, input int v, input int s, input logic w, input logic [16:0] a);
    @(negedge clk);
    h_cnt = 10'(h); v_cnt = 10'(v); map_sel = 2'(s); drv_pix = 1'b1;
    pix_q.push_back('{w, a});
  endtask

  task automatic pix(input int h, input int v, input int s);
    logic w; logic [16:0] a;
    pmodel(h, v, s, w, a);
    pix_e(h, v, s, w, a);
  endtask

  task automatic pix_stop();
    @(negedge clk);
    drv_pix = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Returns at the negedge following the accepting edge
  task automatic query(input int m, input int x, input int y, input logic exp);
    int n = 0;
    @(negedge clk);
    while (!q_ready && n < 50) begin @(negedge clk); n++; end
    chk("q_ready_wait", q_ready, 1);
    q_map = 2'(m); q_x = 7'(x); q_y = 7'(y); q_valid = 1'b1;
    qry_q.push_back('{exp, cyc + 1});
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (qry_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("resp_timeout", qry_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] ones;
    logic [39:0] col7;
    ones = '1;
    col7 = 40'd1 << (39 - 7);
    for (int m = 0; m < 4; m++) for (int r = 0; r < 40; r++) mem_m[m][r] = '0;

    repeat (3) @(negedge clk);
    chk("rst_is_wall", is_wall, 0);
    chk("rst_pixel_addr", pixel_addr, 0);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    rst_n = 1'b1;

    // Render basics
    wr(0, 0, ones);
    pix_e(120, 60, 0, 1'b1, 17'd38400);
    pix_e(0, 0, 0, 1'b0, 17'd0);
    pix_e(131, 62, 0, 1'b1, 17'd38720);
    pix_e(119, 60, 0, 1'b0, 17'd0);          // x=59, left of window
    pix_stop();

    // Collision hit / miss
    wr(0, 5, col7);
    query(0, 4, 3, 1'b1); wait_resp();
    query(0, 8, 3, 1'b0); wait_resp();

    // Out of bounds on an empty map, with busy window check
    query(2, 38, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("q_ready_busy", q_ready, 0);
      @(negedge clk);
    end
    chk("q_ready_back", q_ready, 1);
    wait_resp();
    query(2, 36, 36, 1'b0); wait_resp();
    query(2, 36, 37, 1'b1); wait_resp();

    // Back-to-back queries
    query(0, 6, 2, 1'b1);
    query(0, 0, 8, 1'b0);
    wait_resp();

    // map_sel toggle at a fixed pixel
    wr(1, 0, '0);
    pix_e(120, 60, 0, 1'b1, 17'd38400);
    pix_e(120, 60, 0, 1'b1, 17'd38400);
    pix_e(120, 60, 1, 1'b0, 17'd0);
    pix_e(120, 60, 1, 1'b0, 17'd0);
    pix_stop();

    // Ignored write past the grid, then random maps, pixels and queries
    wr(3, 45, ones);
    for (int i = 0; i < 24; i++)
      wr($urandom_range(0, 3), $urandom_range(0, 39), {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
    for (int i = 0; i < 300; i++)
      pix($urandom_range(100, 540), $urandom_range(40, 480), $urandom_range(0, 3));
    pix_stop();
    for (int i = 0; i < 20; i++) begin
      int m, x, y;
      m = $urandom_range(0, 3); x = $urandom_range(0, 40); y = $urandom_range(0, 40);
      query(m, x, y, cmodel(m, x, y));
      wait_resp();
    end

    // Reset during SCAN aborts the query and clears the maps
    wr(0, 0, ones);
    query(0, 0, 0, 1'b1);
    rst_n = 1'b0;
    qry_q.delete();
    for (int m = 0; m < 4; m++) for (int r = 0; r < 40; r++) mem_m[m][r] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("q_ready_after_rst", q_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("resp_valid_after_rst", resp_valid, 0);
      @(negedge clk);
    end
    pix(120, 60, 0);
    pix(160, 100, 1);
    pix(300, 200, 3);
    pix_stop();
    query(0, 0, 0, 1'b0); wait_resp();

    chk("pix_q_drain", pix_q.size(), 0);
    chk("qry_q_drain", qry_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
